// File: rtl/task3_msg_check.sv
// -----------------------------------------------------------------------------
// task3_msg_check
//
// Reads the decrypted message out of the RAM written by the decrypt block.
// Each byte is checked against the legal set: lower-case 'a'..'z' and space.
// The scan stops at the first illegal byte. The block reports whether the
// whole message was legal and, if it was not, the address of the first bad
// byte.
//
// Parameters
//   MSG_LEN    number of bytes to read and check (1..256)
//   READ_WAIT  wait cycles between driving d_ram_addr and sampling d_ram_q
//              (1..7)
//
// Ports
//   clk         in   single clock; all state changes on the rising edge
//   rst         in   asynchronous reset, active low
//   start       in   level request; a new check needs start to fall and
//                    then rise again
//   d_ram_q     in   [7:0] read data from the decrypted-message RAM
//   d_ram_addr  out  [7:0] read address into the RAM (the block never writes)
//   done        out  check finished; valid and bad_addr are stable
//   valid       out  every byte was legal; meaningful only while done=1
//   bad_addr    out  [7:0] address of the first illegal byte; 0 when valid=1
//   state       out  [15:0] one-hot state on [4:0]; upper bits are zero
// -----------------------------------------------------------------------------
module task3_msg_check #(
   parameter int MSG_LEN   = 32,
   parameter int READ_WAIT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  d_ram_q,
   output logic [7:0]  d_ram_addr,
   output logic        done,
   output logic        valid,
   output logic [7:0]  bad_addr,
   output logic [15:0] state
);

   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001,
      S_ADDR  = 5'b00010,
      S_WAIT  = 5'b00100,
      S_CHECK = 5'b01000,
      S_DONE  = 5'b10000
   } state_e;

   localparam logic [2:0] WAIT_LOAD = 3'(READ_WAIT - 1);
   // The index is one bit wider than the address so MSG_LEN=256 can end
   // without the index wrapping back to 0.
   localparam logic [8:0] LAST_IDX  = 9'(MSG_LEN - 1);

   state_e      state_q, state_d;
   logic [8:0]  index_q, index_d;
   logic [2:0]  cnt_q,   cnt_d;
   logic        valid_q, valid_d;
   logic [7:0]  bad_q,   bad_d;
   logic        legal;

   assign legal = ((d_ram_q >= 8'd97) && (d_ram_q <= 8'd122)) || (d_ram_q == 8'd32);

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values; the async reset clears them without a clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         index_q <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         bad_q   <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         bad_q   <= bad_d;
      end
   end

   // NOTE: every next-state value is given a default first so no path
   // through the case statement leaves one unassigned (no latches).
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      bad_d   = bad_q;
      unique case (state_q)
         S_IDLE: begin
            index_d = '0;
            if (start) state_d = S_ADDR;
         end
         S_ADDR: begin
            cnt_d   = WAIT_LOAD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == 3'd0) state_d = S_CHECK;
            else               cnt_d   = cnt_q - 3'd1;
         end
         S_CHECK: begin
            if (!legal) begin
               valid_d = 1'b0;
               bad_d   = index_q[7:0];
               state_d = S_DONE;
            end else if (index_q == LAST_IDX) begin
               valid_d = 1'b1;
               bad_d   = '0;
               state_d = S_DONE;
            end else begin
               index_d = index_q + 9'd1;
               state_d = S_ADDR;
            end
         end
         S_DONE: begin
            // Staying here while start is high forces a fall-then-rise
            // before the next check can begin.
            if (!start) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The address is the index itself. It only changes on CHECK -> ADDR,
   // so it holds steady through ADDR and WAIT.
   assign d_ram_addr = index_q[7:0];
   assign done       = (state_q == S_DONE);
   assign valid      = valid_q;
   assign bad_addr   = bad_q;
   assign state      = {11'd0, state_q};

endmodule

// File: tb/tb_task3_msg_check.sv
// -----------------------------------------------------------------------------
// tb_task3_msg_check
//
// Directed bench for task3_msg_check. Instance A uses the default parameters
// (MSG_LEN=32, READ_WAIT=1). Instance B uses MSG_LEN=4, READ_WAIT=3. Each
// instance reads its own synchronous-read RAM model with one cycle of latency.
//
// Edge numbering: edge 1 is the first rising edge that samples start=1 while
// the DUT is in IDLE.
// -----------------------------------------------------------------------------
module tb_task3_msg_check;

   localparam logic [15:0] ST_IDLE = 16'h0001;
   localparam logic [15:0] ST_DONE = 16'h0010;

   logic        clk;
   logic        rst;
   logic        start_a, start_b;
   logic [7:0]  q_a, q_b;
   logic [7:0]  addr_a, addr_b;
   logic        done_a, done_b;
   logic        valid_a, valid_b;
   logic [7:0]  bad_a, bad_b;
   logic [15:0] state_a, state_b;

   logic [7:0]  mem_a [256];
   logic [7:0]  mem_b [256];
   int          rd_cnt [256];
   int          max_addr;
   int          hold_cnt, hold_min, hold_max;

   int tests;
   int fails;

   task3_msg_check dut_a (
      .clk        (clk),
      .rst        (rst),
      .start      (start_a),
      .d_ram_q    (q_a),
      .d_ram_addr (addr_a),
      .done       (done_a),
      .valid      (valid_a),
      .bad_addr   (bad_a),
      .state      (state_a)
   );

   task3_msg_check #(.MSG_LEN(4), .READ_WAIT(3)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .start      (start_b),
      .d_ram_q    (q_b),
      .d_ram_addr (addr_b),
      .done       (done_b),
      .valid      (valid_b),
      .bad_addr   (bad_b),
      .state      (state_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      q_a <= mem_a[addr_a];
      q_b <= mem_b[addr_b];
   end

   // Record each byte instance A consumes: CHECK is one-hot bit 3.
   always @(posedge clk) begin
      if (state_a[3]) begin
         rd_cnt[addr_a] = rd_cnt[addr_a] + 1;
         if (int'(addr_a) > max_addr) max_addr = int'(addr_a);
      end
   end

   // Count how many cycles instance B holds each address (ADDR + WAIT)
   // before it reaches CHECK.
   always @(posedge clk) begin
      if (state_b[1] || state_b[2]) begin
         hold_cnt = hold_cnt + 1;
      end else if (state_b[3]) begin
         if (hold_cnt < hold_min) hold_min = hold_cnt;
         if (hold_cnt > hold_max) hold_max = hold_cnt;
         hold_cnt = 0;
      end
   end

   task automatic check(input string tag, input int observed, input int expected);
      tests++;
      assert (observed === expected)
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic fill_a(input logic [7:0] v);
      for (int i = 0; i < 256; i++) mem_a[i] = v;
   endtask

   task automatic clear_reads();
      for (int i = 0; i < 256; i++) rd_cnt[i] = 0;
      max_addr = -1;
   endtask

   // Raise start on instance A and count edges until done rises.
   task automatic run_a(input string tag, input int exp_edge,
                        input int exp_valid, input int exp_bad);
      int n;
      n = 0;
      clear_reads();
      start_a = 1'b1;
      do begin
         @(posedge clk);
         n++;
         #1;
      end while (!done_a && n < 2000);
      check({tag, " done_edge"}, n, exp_edge);
      check({tag, " valid"}, int'(valid_a), exp_valid);
      check({tag, " bad_addr"}, int'(bad_a), exp_bad);
   endtask

   task automatic drop_a();
      @(negedge clk);
      start_a = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Count the addresses in 0..31 that were not read exactly once, plus
   // any reads beyond the message.
   function automatic int read_errors();
      int e;
      e = 0;
      for (int i = 0; i < 256; i++) begin
         if (i < 32 && rd_cnt[i] != 1) e++;
         if (i >= 32 && rd_cnt[i] != 0) e++;
      end
      return e;
   endfunction

   initial begin
      int n;
      tests    = 0;
      fails    = 0;
      start_a  = 1'b0;
      start_b  = 1'b0;
      hold_cnt = 0;
      hold_min = 1000;
      hold_max = 0;
      fill_a(8'd97);
      for (int i = 0; i < 256; i++) mem_b[i] = 8'd97;
      clear_reads();

      // Reset state.
      rst = 1'b0;
      #12;
      check("reset state",    int'(state_a), int'(ST_IDLE));
      check("reset done",     int'(done_a), 0);
      check("reset valid",    int'(valid_a), 0);
      check("reset bad_addr", int'(bad_a), 0);
      check("reset addr",     int'(addr_a), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("idle without start", int'(state_a), int'(ST_IDLE));

      // All 'a': done at edge 1+32*3=97, every address read once.
      run_a("all_a", 97, 1, 0);
      check("all_a read pattern", read_errors(), 0);
      drop_a();

      // 'A' at address 5, spaces elsewhere: stop early at edge 19.
      fill_a(8'd32);
      mem_a[5] = 8'd65;
      run_a("bad_at_5", 19, 0, 5);
      check("bad_at_5 max addr", max_addr, 5);
      drop_a();
      check("idle keeps valid",    int'(valid_a), 0);
      check("idle keeps bad_addr", int'(bad_a), 5);

      // Boundary values just outside and on the edges of the legal set.
      fill_a(8'd97);
      mem_a[0] = 8'd96;
      run_a("byte_96", 4, 0, 0);
      drop_a();
      mem_a[0] = 8'd123;
      run_a("byte_123", 4, 0, 0);
      drop_a();
      fill_a(8'd122);
      run_a("all_122", 97, 1, 0);
      drop_a();
      fill_a(8'd32);
      run_a("all_space", 97, 1, 0);
      drop_a();

      // bad_addr=5 left over from an illegal scan, then reset mid-scan.
      mem_a[5] = 8'd65;
      run_a("pre_reset", 19, 0, 5);
      drop_a();
      fill_a(8'd97);
      start_a = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("before reset addr", int'(addr_a != 8'd0), 1);
      rst = 1'b0;
      #1;
      check("async rst state",    int'(state_a), int'(ST_IDLE));
      check("async rst addr",     int'(addr_a), 0);
      check("async rst done",     int'(done_a), 0);
      check("async rst valid",    int'(valid_a), 0);
      check("async rst bad_addr", int'(bad_a), 0);
      @(negedge clk);
      rst = 1'b1;
      run_a("after_reset", 97, 1, 0);
      check("after_reset read pattern", read_errors(), 0);

      // start held high: stay in DONE, then fall and rise for a new scan.
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (done_a) n++;
      end
      check("done held cycles", n, 10);
      drop_a();
      check("drop start state", int'(state_a), int'(ST_IDLE));
      check("drop start done",  int'(done_a), 0);
      run_a("rescan", 97, 1, 0);
      check("rescan read pattern", read_errors(), 0);
      drop_a();

      // Instance B: MSG_LEN=4, READ_WAIT=3 -> done at edge 1+4*5=21.
      start_b = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
      end while (!done_b && n < 2000);
      check("rw3 done_edge", n, 21);
      check("rw3 valid",     int'(valid_b), 1);
      check("rw3 state",     int'(state_b), int'(ST_DONE));
      check("rw3 hold min",  hold_min, 4);
      check("rw3 hold max",  hold_max, 4);
      start_b = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
